uart_tx_fifo: RTL and testbench

//  Byte FIFO + launcher sitting directly upstream of the uart transmitter.

---
 rtl/uart_tx_fifo_pkg.sv | 22 ++
 rtl/uart_tx_fifo_byte_fifo.sv | 83 ++++++++
 rtl/uart_tx_fifo.sv | 109 ++++++++++
 tb/tb_uart_tx_fifo.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// ============================================================================
// Module  : uart_tx_fifo_pkg
// Purpose : Shared launcher state encoding and UART timing constants.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } tx_state_e;

  localparam int CLKFREQ      = 1000000;
  localparam int BAUD         = 100000;
  localparam int CLKS_PER_BIT = CLKFREQ / BAUD;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo_byte_fifo.sv
// ============================================================================
// Module  : byte_fifo
// Purpose : Byte storage with pointers, fill level, full/almost-full and flush.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int AFULL = 12
) (
  input  logic          clk,
  input  logic          resetq,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [7:0]    rd_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          almost_full
);

  localparam logic [AW:0]   FULL_LEVEL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AFULL_LEVEL = (AW+1)'(AFULL);
  localparam logic [AW:0]   LEVEL_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok;
  logic          pop_ok;

  // Full is judged on the registered level, so a push at DEPTH is dropped
  // even when a pop frees a slot in the same cycle.
  always_comb begin
    push_ok = push & ~full & ~flush;
    pop_ok  = pop & ~flush & (level_q != '0);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PTR_ONE;
      if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LEVEL_ONE;
        2'b01:   level_d = level_q - LEVEL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_data;
  end

  assign rd_data     = mem_q[rptr_q];
  assign level       = level_q;
  assign full        = (level_q == FULL_LEVEL);
  assign almost_full = (level_q >= AFULL_LEVEL);

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module  : uart_tx_fifo
// Purpose : Byte FIFO plus launcher feeding one byte at a time to a UART tx.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int AFULL = 12
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        wr,
  input  logic [7:0]  wr_data,
  input  logic        flush,
  input  logic        clr_ovf,
  output logic        full,
  output logic        almost_full,
  output logic [AW:0] level,
  output logic        overflow,
  output logic        idle,
  output logic        uart_wr,
  output logic [7:0]  uart_dat,
  input  logic        uart_busy
);

  tx_state_e   state_q, state_d;
  logic        uart_wr_q, uart_wr_d;
  logic [7:0]  uart_dat_q, uart_dat_d;
  logic        overflow_q, overflow_d;
  logic        pop;
  logic [7:0]  fifo_rd_data;

  byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .AFULL (AFULL)
  ) u_fifo (
    .clk         (clk),
    .resetq      (resetq),
    .push        (wr),
    .push_data   (wr_data),
    .pop         (pop),
    .flush       (flush),
    .rd_data     (fifo_rd_data),
    .level       (level),
    .full        (full),
    .almost_full (almost_full)
  );

  // One byte in flight: launch only from S_IDLE, then wait for the uart's
  // busy to rise and fall before considering the next byte.
  always_comb begin
    state_d    = state_q;
    uart_wr_d  = 1'b0;
    uart_dat_d = uart_dat_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((level != '0) && !uart_busy && !flush) begin
          pop        = 1'b1;
          uart_wr_d  = 1'b1;
          uart_dat_d = fifo_rd_data;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (uart_busy) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!uart_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A flushed push is discarded rather than dropped; a drop beats clr_ovf.
  always_comb begin
    overflow_d = overflow_q;
    if (wr && full && !flush) overflow_d = 1'b1;
    else if (clr_ovf)         overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q    <= S_IDLE;
      uart_wr_q  <= 1'b0;
      uart_dat_q <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      uart_wr_q  <= uart_wr_d;
      uart_dat_q <= uart_dat_d;
      overflow_q <= overflow_d;
    end
  end

  assign uart_wr  = uart_wr_q;
  assign uart_dat = uart_dat_q;
  assign overflow = overflow_q;
  assign idle     = (level == '0) && (state_q == S_IDLE) && !uart_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module  : tb_uart_tx_fifo
// Purpose : Directed bench for uart_tx_fifo with a behavioural uart tx model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       resetq = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       force_busy = 1'b0;
  logic       full, almost_full, overflow, idle, uart_wr, uart_busy;
  logic [4:0] level;
  logic [7:0] uart_dat;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.DEPTH(16), .AW(4), .AFULL(12)) dut (
    .clk         (clk),
    .resetq      (resetq),
    .wr          (wr),
    .wr_data     (wr_data),
    .flush       (flush),
    .clr_ovf     (clr_ovf),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow),
    .idle        (idle),
    .uart_wr     (uart_wr),
    .uart_dat    (uart_dat),
    .uart_busy   (uart_busy)
  );

  always #5 clk = ~clk;

  // Behavioural uart: 10 clk/bit, start + 8 data (LSB first) + stop.
  logic       model_busy;
  logic [9:0] sh;
  logic [9:0] rx_frame;
  int         cnt, bitn;
  logic       tx;
  assign tx        = model_busy ? sh[bitn] : 1'b1;
  assign uart_busy = model_busy | force_busy;

  always @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      model_busy <= 1'b0;
      sh         <= '1;
      rx_frame   <= '0;
      cnt        <= 0;
      bitn       <= 0;
    end else if (!model_busy) begin
      if (uart_wr) begin
        sh         <= {1'b1, uart_dat, 1'b0};
        model_busy <= 1'b1;
        cnt        <= 0;
        bitn       <= 0;
      end
    end else begin
      if (cnt == 4) rx_frame <= {tx, rx_frame[9:1]};
      if (cnt == CLKS_PER_BIT - 1) begin
        cnt <= 0;
        if (bitn == 9) model_busy <= 1'b0;
        else           bitn <= bitn + 1;
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  logic [7:0] log_q[$];
  int         consec = 0;
  logic       prev_wr = 1'b0;
  always @(posedge clk) begin
    if (uart_wr) begin
      log_q.push_back(uart_dat);
      if (prev_wr) consec <= consec + 1;
    end
    prev_wr <= uart_wr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    wr = 1'b1;
    wr_data = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (!idle && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL reset_uart_wr: got %b expected 0", uart_wr); end
    checks++; if (uart_dat !== 8'h00) begin errors++; $display("FAIL reset_uart_dat: got %h expected 00", uart_dat); end
    checks++; if ({full, almost_full} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {full, almost_full}); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
  endtask

  task automatic test_single();
    int n;
    log_q.delete();
    push_byte(8'hA5);
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level: got %0d expected 1", level); end
    checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL single_early_wr: got %b expected 0", uart_wr); end
    tick();
    checks++; if ({uart_wr, uart_dat} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL single_launch: got wr=%b dat=%h expected wr=1 dat=a5", uart_wr, uart_dat); end
    tick();
    checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b expected 0", uart_wr); end
    wait_idle(200, n);
    checks++; if (n < 90 || n > 110) begin errors++; $display("FAIL single_idle_time: got %0d cycles expected 90..110", n); end
    checks++; if (rx_frame !== {1'b1, 8'hA5, 1'b0}) begin errors++; $display("FAIL single_tx_frame: got %b expected 1101001010", rx_frame); end
    checks++; if (log_q.size() != 1) begin errors++; $display("FAIL single_wr_count: got %0d expected 1", log_q.size()); end
  endtask

  task automatic test_burst();
    int n;
    log_q.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i));
      checks++; if (level !== 5'(i + 1)) begin errors++; $display("FAIL burst_level: got %0d expected %0d", level, i + 1); end
      checks++; if (almost_full !== (i + 1 >= 12)) begin errors++; $display("FAIL burst_afull: got %b expected %b at level %0d", almost_full, (i + 1 >= 12), i + 1); end
      checks++; if (full !== (i + 1 == 16)) begin errors++; $display("FAIL burst_full: got %b expected %b at level %0d", full, (i + 1 == 16), i + 1); end
    end
    force_busy = 1'b0;
    wait_idle(2000, n);
    checks++; if (n >= 2000) begin errors++; $display("FAIL burst_timeout: got %0d cycles expected <2000", n); end
    checks++; if (log_q.size() != 16) begin errors++; $display("FAIL burst_count: got %0d expected 16", log_q.size()); end
    for (int i = 0; i < 16 && i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== 8'(i)) begin errors++; $display("FAIL burst_order[%0d]: got %h expected %h", i, log_q[i], 8'(i)); end
    end
    checks++; if (consec != 0) begin errors++; $display("FAIL burst_consec_wr: got %0d expected 0", consec); end
  endtask

  task automatic test_overflow();
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push_byte(8'h40 + 8'(i));
      if (i == 15) begin
        checks++; if ({full, overflow} !== 2'b10) begin errors++; $display("FAIL ovf_at_16: got full,ovf=%b expected 10", {full, overflow}); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", level); end
    clr_ovf = 1'b1; tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    wr = 1'b1; tick(); wr = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
    tick(); clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_reclear: got %b expected 0", overflow); end
  endtask

  task automatic test_push_pop_full();
    int n;
    log_q.delete();
    wr = 1'b1; wr_data = 8'hEE; force_busy = 1'b0;
    tick();
    wr = 1'b0;
    checks++; if (level !== 5'd15) begin errors++; $display("FAIL pp16_level: got %0d expected 15", level); end
    checks++; if ({uart_wr, uart_dat} !== {1'b1, 8'h40}) begin errors++; $display("FAIL pp16_launch: got wr=%b dat=%h expected wr=1 dat=40", uart_wr, uart_dat); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL pp16_dropped: got %b expected 1", overflow); end
    clr_ovf = 1'b1; flush = 1'b1; tick(); clr_ovf = 1'b0; flush = 1'b0;
    checks++; if ({level, overflow} !== {5'd0, 1'b0}) begin errors++; $display("FAIL pp16_flush: got level=%0d ovf=%b expected 0/0", level, overflow); end
    wait_idle(300, n);
    checks++; if (n >= 300) begin errors++; $display("FAIL pp16_timeout: got %0d cycles expected <300", n); end
    checks++; if (log_q.size() != 1) begin errors++; $display("FAIL pp16_count: got %0d expected 1", log_q.size()); end
  endtask

  task automatic test_push_pop_5();
    int n;
    log_q.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
    wr = 1'b1; wr_data = 8'h55; force_busy = 1'b0;
    tick();
    wr = 1'b0;
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL pp5_level: got %0d expected 5", level); end
    checks++; if ({uart_wr, uart_dat} !== {1'b1, 8'h50}) begin errors++; $display("FAIL pp5_launch: got wr=%b dat=%h expected wr=1 dat=50", uart_wr, uart_dat); end
    wait_idle(1000, n);
    checks++; if (n >= 1000) begin errors++; $display("FAIL pp5_timeout: got %0d cycles expected <1000", n); end
    checks++; if (log_q.size() != 6) begin errors++; $display("FAIL pp5_count: got %0d expected 6", log_q.size()); end
    if (log_q.size() == 6) begin
      checks++; if (log_q[5] !== 8'h55) begin errors++; $display("FAIL pp5_last: got %h expected 55", log_q[5]); end
    end
  endtask

  task automatic test_flush();
    int n;
    log_q.delete();
    force_busy = 1'b1;
    push_byte(8'h3C);
    for (int i = 1; i <= 6; i++) push_byte(8'(i));
    force_busy = 1'b0;
    tick();
    checks++; if ({uart_wr, uart_dat, level} !== {1'b1, 8'h3C, 5'd6}) begin errors++; $display("FAIL flush_launch: got wr=%b dat=%h level=%0d expected 1/3c/6", uart_wr, uart_dat, level); end
    repeat (5) tick();
    wr = 1'b1; wr_data = 8'h77; flush = 1'b1;
    tick();
    wr = 1'b0; flush = 1'b0;
    checks++; if ({level, overflow} !== {5'd0, 1'b0}) begin errors++; $display("FAIL flush_level: got level=%0d ovf=%b expected 0/0", level, overflow); end
    wait_idle(300, n);
    checks++; if (n >= 300) begin errors++; $display("FAIL flush_timeout: got %0d cycles expected <300", n); end
    repeat (20) tick();
    checks++; if (log_q.size() != 1) begin errors++; $display("FAIL flush_no_more_wr: got %0d expected 1", log_q.size()); end
    checks++; if (rx_frame[8:1] !== 8'h3C) begin errors++; $display("FAIL flush_inflight: got %h expected 3c", rx_frame[8:1]); end
    // flush beats a pop that would otherwise launch in the same cycle
    force_busy = 1'b1;
    push_byte(8'h11);
    push_byte(8'h22);
    force_busy = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if ({uart_wr, level} !== {1'b0, 5'd0}) begin errors++; $display("FAIL flush_vs_pop: got wr=%b level=%0d expected 0/0", uart_wr, level); end
    tick();
    checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL flush_vs_pop_late: got %b expected 0", uart_wr); end
  endtask

  task automatic test_reset_mid();
    int n;
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'h91 + 8'(i));
    force_busy = 1'b0;
    repeat (5) tick();
    checks++; if ({level, uart_dat} !== {5'd4, 8'h91}) begin errors++; $display("FAIL rstmid_pre: got level=%0d dat=%h expected 4/91", level, uart_dat); end
    resetq = 1'b0;
    #1;
    checks++; if ({level, overflow, uart_wr, uart_dat} !== 15'd0) begin errors++; $display("FAIL rstmid_regs: got level=%0d ovf=%b wr=%b dat=%h expected all 0", level, overflow, uart_wr, uart_dat); end
    checks++; if ({full, almost_full, idle} !== 3'b001) begin errors++; $display("FAIL rstmid_flags: got %b expected 001", {full, almost_full, idle}); end
    tick();
    resetq = 1'b1;
    tick();
    push_byte(8'h5A);
    tick();
    checks++; if ({uart_wr, uart_dat} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL rstmid_after: got wr=%b dat=%h expected 1/5a", uart_wr, uart_dat); end
    wait_idle(300, n);
    checks++; if (n >= 300) begin errors++; $display("FAIL rstmid_timeout: got %0d cycles expected <300", n); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    test_reset();
    resetq = 1'b1;
    tick();
    test_single();
    test_burst();
    test_overflow();
    test_push_pop_full();
    test_push_pop_5();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
